// File: rtl/bcd_sub_serial_if.sv
// Operand/result handshake bundle for bcd_sub_serial: operand channel (in_*, a, b)
// and result channel (out_*, diff, minus, err).
interface bcd_sub_serial_if #(
    parameter int DIGITS = 2
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   diff;
    logic [3:0]            minus;
    logic                  err;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, minus, err
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, minus, err
    );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial |a - b| for packed-BCD operands, one digit per clock, with a ten's
// complement pass for negative results. Optional operand check: BCD_SUB_ERR_CHECK_EN.
module bcd_sub_serial #(
    parameter int DIGITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_sub_serial_if.slave      bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    state_t          state_r, state_n;
    logic [W-1:0]    a_r, a_n, b_r, b_n, work_r, work_n;
    logic [IW-1:0]   idx_r, idx_n;
    logic            borrow_r, borrow_n;
    logic [3:0]      minus_r, minus_n;
    logic            in_ready_r, out_valid_r;
    logic [4:0]      ds_s;
    logic            last_s;

    // Returns {borrow_out, digit}: x - y - bin, wrapped by +10 when negative.
    function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y,
                                             input logic bin);
        logic [4:0] t;
        t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        if (t[4]) begin
            digit_sub = {1'b1, t[3:0] + 4'd10};
        end else begin
            digit_sub = {1'b0, t[3:0]};
        end
    endfunction

`ifdef BCD_SUB_ERR_CHECK_EN
    logic err_r, err_n;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        has_bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*4 +: 4] > 4'd9) begin
                has_bad_digit = 1'b1;
            end else begin
                has_bad_digit = has_bad_digit;
            end
        end
    endfunction

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    assign last_s        = (idx_r == IW'(DIGITS - 1));
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = work_r;
    assign bus.minus     = minus_r;

    // Next-state and datapath update for the digit-serial FSM.
    always_comb begin
        state_n  = state_r;
        a_n      = a_r;
        b_n      = b_r;
        work_n   = work_r;
        idx_n    = idx_r;
        borrow_n = borrow_r;
        minus_n  = minus_r;
        ds_s     = 5'd0;
`ifdef BCD_SUB_ERR_CHECK_EN
        err_n    = err_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    a_n      = bus.a;
                    b_n      = bus.b;
                    work_n   = '0;
                    idx_n    = '0;
                    borrow_n = 1'b0;
                    minus_n  = 4'd0;
                    state_n  = SUB;
`ifdef BCD_SUB_ERR_CHECK_EN
                    err_n    = has_bad_digit(bus.a) | has_bad_digit(bus.b);
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            SUB: begin
`ifdef BCD_SUB_ERR_CHECK_EN
                if (err_r) begin
                    state_n = DONE;
                end else begin
`else
                begin
`endif
                    ds_s = digit_sub(a_r[idx_r*4 +: 4], b_r[idx_r*4 +: 4], borrow_r);
                    work_n[idx_r*4 +: 4] = ds_s[3:0];
                    borrow_n = ds_s[4];
                    if (!last_s) begin
                        idx_n = idx_r + 1'b1;
                    end else if (ds_s[4]) begin
                        // Final borrow means a < b: complement the raw result.
                        minus_n  = 4'd10;
                        idx_n    = '0;
                        borrow_n = 1'b0;
                        state_n  = NEG;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            NEG: begin
                ds_s = digit_sub(4'd0, work_r[idx_r*4 +: 4], borrow_r);
                work_n[idx_r*4 +: 4] = ds_s[3:0];
                borrow_n = ds_s[4];
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx_r + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            work_r      <= '0;
            idx_r       <= '0;
            borrow_r    <= 1'b0;
            minus_r     <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef BCD_SUB_ERR_CHECK_EN
            err_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            a_r         <= a_n;
            b_r         <= b_n;
            work_r      <= work_n;
            idx_r       <= idx_n;
            borrow_r    <= borrow_n;
            minus_r     <= minus_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
`ifdef BCD_SUB_ERR_CHECK_EN
            err_r       <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed self-checking bench for bcd_sub_serial: a 2-digit and a 4-digit instance
// with hand-computed results, latency, backpressure and mid-operation reset.
module tb_bcd_sub_serial;
    logic clk = 1'b0;
    logic rst2_n, rst4_n;
    int   checks = 0;
    int   errors = 0;

    bcd_sub_serial_if #(.DIGITS(2)) bus2 ();
    bcd_sub_serial_if #(.DIGITS(4)) bus4 ();

    bcd_sub_serial #(.DIGITS(2)) u2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));
    bcd_sub_serial #(.DIGITS(4)) u4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tx2(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic [3:0] em, input logic ee,
                       input int el);
        int n;
        check({tag, "_in_ready"}, 32'(bus2.in_ready), 32'd1);
        bus2.a = a; bus2.b = b; bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        n = 0;
        while (!bus2.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(el));
        check({tag, "_diff"}, 32'(bus2.diff), 32'(ed));
        check({tag, "_minus"}, 32'(bus2.minus), 32'(em));
        check({tag, "_err"}, 32'(bus2.err), 32'(ee));
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        check({tag, "_drop"}, {30'd0, bus2.out_valid, bus2.in_ready}, 32'd1);
    endtask

    task automatic tx4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic [3:0] em, input int el);
        int n;
        check({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
        bus4.a = a; bus4.b = b; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(el));
        check({tag, "_diff"}, 32'(bus4.diff), 32'(ed));
        check({tag, "_minus"}, 32'(bus4.minus), 32'(em));
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check({tag, "_drop"}, {30'd0, bus4.out_valid, bus4.in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst2_n = 1'b0; rst4_n = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.a = 8'h00; bus2.b = 8'h00;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = 16'h0000; bus4.b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst2_n = 1'b1; rst4_n = 1'b1;
        check("rst2", {bus2.in_ready, bus2.out_valid, bus2.err, bus2.minus, 8'(bus2.diff)},
              {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
        check("rst4", {bus4.in_ready, bus4.out_valid, bus4.err, bus4.minus, bus4.diff},
              {1'b1, 1'b0, 1'b0, 4'd0, 16'h0000});

        tx2("d2_pos", 8'h73, 8'h28, 8'h45, 4'd0, 1'b0, 2);
        tx2("d2_neg", 8'h28, 8'h73, 8'h45, 4'd10, 1'b0, 4);
        tx2("d2_eq", 8'h50, 8'h50, 8'h00, 4'd0, 1'b0, 2);
        tx4("d4_borrow", 16'h1000, 16'h0001, 16'h0999, 4'd0, 4);
        tx4("d4_neg", 16'h0000, 16'h9999, 16'h9999, 4'd10, 8);

        // Backpressure: result held while out_ready stays low; new operands ignored.
        bus2.a = 8'h91; bus2.b = 8'h19; bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.a = 8'h11; bus2.b = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", {bus2.out_valid, bus2.in_ready, bus2.minus, 8'(bus2.diff)},
                  {1'b1, 1'b0, 4'd0, 8'h72});
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        check("bp_release", {30'd0, bus2.out_valid, bus2.in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_accept", {30'd0, bus2.out_valid, bus2.in_ready}, 32'd1);

        // Reset during SUB aborts the operation.
        bus4.a = 16'h1234; bus4.b = 16'h0001; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b1;
        check("midrst", {bus4.in_ready, bus4.out_valid, bus4.err, bus4.minus, bus4.diff},
              {1'b1, 1'b0, 1'b0, 4'd0, 16'h0000});
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus4.out_valid) seen++;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        tx4("d4_after_rst", 16'h0042, 16'h0017, 16'h0025, 4'd0, 4);

`ifdef BCD_SUB_ERR_CHECK_EN
        tx2("err_set", 8'h3A, 8'h10, 8'h00, 4'd0, 1'b1, 1);
        tx2("err_clr", 8'h73, 8'h28, 8'h45, 4'd0, 1'b0, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_sub_serial.md
# bcd_sub_serial

Digit-serial, parametrised BCD subtractor computing |A − B| of two DIGITS-wide packed-BCD operands, plus a sign code for the seven-segment display path. It replaces the fixed two-digit combinational subtractor in the calculator datapath. Ripple-borrow runs one digit per clock, with a second complement pass for negative results. Input and output use valid/ready handshakes so it sits between the keypad operand registers and the display scan driver.

## Interface
- DIGITS, 2: number of BCD digits per operand (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0].
- b  in  4*DIGITS  subtrahend, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- diff  out  4*DIGITS  |a − b|, packed BCD.
- minus  out  4  sign display code: 4'd10 if a < b, else 4'd0.
- err  out  1  non-BCD operand digit detected (see Configuration).

## Operation
- FSM states: IDLE, SUB, NEG, DONE. in_ready = (state == IDLE).
- IDLE: on in_valid & in_ready, latch a, b; clear borrow, digit index i = 0; go SUB.
- SUB: one digit per cycle, i = 0..DIGITS−1: t = a_i − b_i − borrow (signed); if t < 0 then r_i = t + 10, borrow = 1, else r_i = t, borrow = 0. r_i is 4-bit.
- After digit DIGITS−1: if borrow = 0, minus = 0, go DONE. If borrow = 1, minus = 4'd10, reset i = 0 and borrow = 0, go NEG.
- NEG: per digit, r_i ← 0 − r_i − borrow with the same rule (ten's complement); after digit DIGITS−1, go DONE.
- DONE: out_valid = 1; diff, minus, err held stable. On out_ready, go IDLE.
- a == b gives diff = 0 and minus = 0. There is no negative zero.
- Operands are latched; a and b may change freely after acceptance.

## Timing
- Reset: on any clk edge with rst_n = 0, state becomes IDLE and diff, minus, err, out_valid, and internal registers clear to 0. in_ready is 1 from the first cycle after reset.
- Reset mid-SUB, mid-NEG, or in DONE aborts the operation. The pending result is lost and no out_valid is produced.
- Accept at edge k. Non-negative result: out_valid rises after edge k+DIGITS. Negative result: out_valid rises after edge k+2·DIGITS.
- out_valid stays high until the edge where out_ready = 1. It is low the following cycle, and in_ready returns high the same cycle. Minimum gap between results is one IDLE cycle.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Configuration
- BCD_SUB_ERR_CHECK_EN defined: at acceptance, if any digit of a or b exceeds 9, skip SUB/NEG and go straight to DONE after edge k+1 with err = 1, diff = 0, minus = 0. err clears when the next operands are accepted or on reset.
- Not defined: err is tied to 0 and no check logic is built. Non-BCD digits go through the same per-digit rule with 4-bit truncation. The result is deterministic but meaningless.

## Test plan
- DIGITS=2, a=0x73, b=0x28 -> diff=0x45, minus=0, out_valid 2 cycles after acceptance.
- DIGITS=2, a=0x28, b=0x73 -> diff=0x45, minus=10, out_valid 4 cycles after acceptance. Also a=0x50, b=0x50 -> diff=0x00, minus=0.
- DIGITS=4, a=0x1000, b=0x0001 -> diff=0x0999, minus=0. Also a=0x0000, b=0x9999 -> diff=0x9999, minus=10, latency 8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, diff, and minus stable, in_ready=0 and new in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- rst_n=0 for one edge during SUB (DIGITS=4, cycle 2) -> all outputs 0, no out_valid. The next transaction 0x0042−0x0017 gives diff=0x0025.
- With BCD_SUB_ERR_CHECK_EN: a=0x3A, b=0x10 -> err=1, diff=0, minus=0, out_valid 1 cycle after acceptance. The next valid pair clears err.
